// File: rtl/hardware_ram_arbiter_2.sv
// Two-requester arbiter in front of a 512x64 RAM: round-robin grant, lock for RMW, tag-routed responses.
// Define HARDWARE_RAM_ARB_FIXED_PRIO_EN to replace round-robin with fixed priority (req0 wins).
module hardware_ram_arbiter_2 #(
    parameter int unsigned RAM_LAT = 2,
    parameter int unsigned DEPTH   = 512,
    parameter int unsigned ADDR_W  = 30,
    parameter int unsigned DATA_W  = 64,
    localparam int unsigned REQ_W  = 2 + ADDR_W + DATA_W,
    localparam int unsigned RSP_W  = 2 + DATA_W
) (
    input  logic             system1000,
    input  logic             system1000_rstn,
    input  logic [REQ_W-1:0] req0_i,
    input  logic             req0_lock_i,
    output logic             req0_ready_o,
    output logic [RSP_W-1:0] rsp0_o,
    output logic             rsp0_err_o,
    input  logic [REQ_W-1:0] req1_i,
    input  logic             req1_lock_i,
    output logic             req1_ready_o,
    output logic [RSP_W-1:0] rsp1_o,
    output logic             rsp1_err_o,
    output logic [REQ_W-1:0] ram_req_o,
    input  logic [RSP_W-1:0] ram_rsp_i,
    output logic             err_o
);

    typedef struct packed {
        logic              vld;
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } req_t;

    typedef struct packed {
        logic              vld;
        logic              wack;
        logic [DATA_W-1:0] data;
    } rsp_t;

    typedef struct packed {
        logic vld;
        logic id;
        logic wr;
        logic oob;
    } tag_t;

    typedef enum logic [1:0] {
        ST_RR   = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } state_e;

    state_e state_q, state_d;
    logic   last_gnt_q, last_gnt_d;
    logic   err_q, err_d;
    req_t   ram_req_q, ram_req_d;
    tag_t   tag_q [0:RAM_LAT];
    tag_t   tag_d;

    req_t r0, r1, sel;
    rsp_t ram_rsp, rsp_sel;
    tag_t head;
    logic gnt0, gnt1, acc, sel_lock, oob;

    assign r0      = req0_i;
    assign r1      = req1_i;
    assign ram_rsp = ram_rsp_i;
    assign head    = tag_q[RAM_LAT];

    // Grant, lock FSM next state and issue path
    always_comb begin
        gnt0       = 1'b0;
        gnt1       = 1'b0;
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        ram_req_d  = '0;
        tag_d      = '0;

        unique case (state_q)
            ST_RR: begin
`ifdef HARDWARE_RAM_ARB_FIXED_PRIO_EN
                gnt0 = r0.vld;
                gnt1 = r1.vld & ~r0.vld;
`else
                if (r0.vld && r1.vld) begin
                    gnt0 = last_gnt_q;
                    gnt1 = ~last_gnt_q;
                end else begin
                    gnt0 = r0.vld;
                    gnt1 = r1.vld;
                end
`endif
            end
            ST_OWN0: gnt0 = r0.vld;
            ST_OWN1: gnt1 = r1.vld;
            default: ;
        endcase

        // No grant is visible while reset is asserted
        if (!system1000_rstn) begin
            gnt0 = 1'b0;
            gnt1 = 1'b0;
        end

        acc      = gnt0 | gnt1;
        sel      = gnt1 ? r1 : r0;
        sel_lock = gnt1 ? req1_lock_i : req0_lock_i;
        oob      = sel.addr >= ADDR_W'(DEPTH);

        if (acc) begin
            last_gnt_d = gnt1;
            state_d    = sel_lock ? (gnt1 ? ST_OWN1 : ST_OWN0) : ST_RR;
            tag_d      = '{vld: 1'b1, id: gnt1, wr: sel.wr, oob: oob};
            if (!oob) begin
                ram_req_d = sel;
            end
        end
    end

    // Response routing from the tag head, aligned with ram_rsp_i
    always_comb begin
        rsp0_o     = '0;
        rsp1_o     = '0;
        rsp0_err_o = 1'b0;
        rsp1_err_o = 1'b0;
        rsp_sel    = ram_rsp;
        err_d      = err_q;

        if (head.vld) begin
            if (head.oob) begin
                rsp_sel = '{vld: 1'b1, wack: head.wr, data: '0};
            end
            if (head.id) begin
                rsp1_o     = rsp_sel;
                rsp1_err_o = head.oob;
            end else begin
                rsp0_o     = rsp_sel;
                rsp0_err_o = head.oob;
            end
        end

        if (ram_rsp.vld && !head.vld) begin
            err_d = 1'b1;
        end
        if (head.vld && !head.oob && (!ram_rsp.vld || (ram_rsp.wack != head.wr))) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge system1000 or negedge system1000_rstn) begin
        if (!system1000_rstn) begin
            state_q    <= ST_RR;
            last_gnt_q <= 1'b1;
            err_q      <= 1'b0;
            ram_req_q  <= '0;
            for (int unsigned k = 0; k <= RAM_LAT; k++) begin
                tag_q[k] <= '0;
            end
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            err_q      <= err_d;
            ram_req_q  <= ram_req_d;
            tag_q[0]   <= tag_d;
            for (int unsigned k = 1; k <= RAM_LAT; k++) begin
                tag_q[k] <= tag_q[k-1];
            end
        end
    end

    assign req0_ready_o = gnt0;
    assign req1_ready_o = gnt1;
    assign ram_req_o    = ram_req_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_hardware_ram_arbiter_2.sv
// Directed bench for hardware_ram_arbiter_2 with a 2-cycle RAM model and a
// cycle-exact response scoreboard.
module tb_hardware_ram_arbiter_2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [95:0] req0, req1, ram_req;
    logic        lk0, lk1, rdy0, rdy1, rerr0, rerr1, err;
    logic [65:0] rsp0, rsp1, ram_rsp;

    always #5 clk = ~clk;

    hardware_ram_arbiter_2 dut (
        .system1000      (clk),
        .system1000_rstn (rst_n),
        .req0_i          (req0),
        .req0_lock_i     (lk0),
        .req0_ready_o    (rdy0),
        .rsp0_o          (rsp0),
        .rsp0_err_o      (rerr0),
        .req1_i          (req1),
        .req1_lock_i     (lk1),
        .req1_ready_o    (rdy1),
        .rsp1_o          (rsp1),
        .rsp1_err_o      (rerr1),
        .ram_req_o       (ram_req),
        .ram_rsp_i       (ram_rsp),
        .err_o           (err)
    );

    // RAM model: registered request stage, registered response stage
    logic [63:0] mem [0:511];
    logic [95:0] ram_a;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_a   <= '0;
            ram_rsp <= '0;
        end else begin
            ram_a   <= ram_req;
            ram_rsp <= '0;
            if (ram_a[95]) begin
                if (ram_a[94]) begin
                    mem[ram_a[72:64]] <= ram_a[63:0];
                    ram_rsp <= {2'b11, 64'd0};
                end else begin
                    ram_rsp <= {2'b10, mem[ram_a[72:64]]};
                end
            end
        end
    end

    typedef struct {
        logic [65:0] rsp;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t        exp0_q [$];
    exp_t        exp1_q [$];
    int          n_vec = 0;
    int          n_bad = 0;
    int          cyc = 0;
    bit          mon_en = 1'b0;
    logic [95:0] pend_ram = '0;
`ifdef HARDWARE_RAM_ARB_FIXED_PRIO_EN
    bit          fixed = 1'b1;
`else
    bit          fixed = 1'b0;
`endif

    localparam logic [65:0] WACK = {2'b11, 64'd0};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    function automatic logic [95:0] mkreq(input logic wr, input logic [29:0] a, input logic [63:0] d);
        return {1'b1, wr, a, d};
    endfunction

    function automatic logic [65:0] rd(input logic [63:0] d);
        return {2'b10, d};
    endfunction

    // Monitor: every cycle each port must show exactly the scheduled response or zero
    always @(negedge clk) begin
        logic [65:0] e0r, e1r;
        logic        e0e, e1e;
        if (mon_en) begin
            e0r = '0; e0e = 1'b0; e1r = '0; e1e = 1'b0;
            if (exp0_q.size() > 0 && exp0_q[0].cyc == cyc) begin
                e0r = exp0_q[0].rsp; e0e = exp0_q[0].err; void'(exp0_q.pop_front());
            end
            if (exp1_q.size() > 0 && exp1_q[0].cyc == cyc) begin
                e1r = exp1_q[0].rsp; e1e = exp1_q[0].err; void'(exp1_q.pop_front());
            end
            chk("rsp0", 96'(rsp0), 96'(e0r));
            chk("rsp0_err", 96'(rerr0), 96'(e0e));
            chk("rsp1", 96'(rsp1), 96'(e1r));
            chk("rsp1_err", 96'(rerr1), 96'(e1e));
            chk("err_o", 96'(err), 96'(0));
        end
    end

    // Apply one cycle of stimulus; check ready and the previous cycle's issue
    task automatic apply(input logic [95:0] q0, input logic l0, input logic [95:0] q1, input logic l1,
                         input logic e0, input logic e1,
                         input logic [65:0] x0, input logic xe0, input logic [65:0] x1, input logic xe1);
        exp_t ex;
        req0 = q0; lk0 = l0; req1 = q1; lk1 = l1;
        @(negedge clk);
        chk("ready0", 96'(rdy0), 96'(e0));
        chk("ready1", 96'(rdy1), 96'(e1));
        chk("ram_req", ram_req, pend_ram);
        pend_ram = '0;
        if (e0) begin
            ex.rsp = x0; ex.err = xe0; ex.cyc = cyc + 3; exp0_q.push_back(ex);
            if (q0[93:64] < 30'd512) pend_ram = q0;
        end else if (e1) begin
            ex.rsp = x1; ex.err = xe1; ex.cyc = cyc + 3; exp1_q.push_back(ex);
            if (q1[93:64] < 30'd512) pend_ram = q1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) apply('0, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [95:0] r5, r6, r8;
        logic        e0;
        r5 = mkreq(1'b0, 30'd5, 64'd0);
        r6 = mkreq(1'b0, 30'd6, 64'd0);
        r8 = mkreq(1'b0, 30'd8, 64'd0);
        for (int i = 0; i < 512; i++) mem[i] = '0;
        mem[5]   = 64'h2A;
        mem[6]   = 64'h66;
        mem[8]   = 64'h88;
        mem[511] = 64'hDEAD_BEEF_0123_4567;

        // Reset: outputs held at zero even with a valid request pending
        rst_n = 1'b0; lk0 = 1'b0; lk1 = 1'b0; req1 = '0; req0 = r5;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready0", 96'(rdy0), 96'(0));
        chk("rst_ram_req", ram_req, 96'(0));
        chk("rst_rsp0", 96'(rsp0), 96'(0));
        chk("rst_err", 96'(err), 96'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1; mon_en = 1'b1; req0 = '0;

        // Single read through to the RAM and back
        apply(r5, 1'b0, '0, 1'b0, 1'b1, 1'b0, rd(64'h2A), 1'b0, '0, 1'b0);
        idle(4);

        // Both requesting: alternate grants, responses in order
        for (int i = 0; i < 5; i++) begin
            e0 = fixed || (i % 2 == 1);
            apply(r5, 1'b0, r6, 1'b0, e0, !e0, rd(64'h2A), 1'b0, rd(64'h66), 1'b0);
        end

        // Locked write/read pair by req0 while req1 waits
        apply(mkreq(1'b1, 30'd7, 64'h11), 1'b1, r8, 1'b0, 1'b1, 1'b0, WACK, 1'b0, '0, 1'b0);
        apply('0, 1'b0, r8, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
        apply(mkreq(1'b0, 30'd7, 64'd0), 1'b0, r8, 1'b0, 1'b1, 1'b0, rd(64'h11), 1'b0, '0, 1'b0);
        apply('0, 1'b0, r8, 1'b0, 1'b0, 1'b1, '0, 1'b0, rd(64'h88), 1'b0);
        idle(4);

        // Address boundary: 512/600 out of bounds, 511 the last valid word
        apply('0, 1'b0, mkreq(1'b0, 30'd512, 64'd0), 1'b0, 1'b0, 1'b1, '0, 1'b0, rd(64'd0), 1'b1);
        apply(mkreq(1'b1, 30'd600, 64'hFF), 1'b0, '0, 1'b0, 1'b1, 1'b0, WACK, 1'b1, '0, 1'b0);
        apply(mkreq(1'b0, 30'd511, 64'd0), 1'b0, '0, 1'b0, 1'b1, 1'b0, rd(64'hDEAD_BEEF_0123_4567), 1'b0, '0, 1'b0);
        idle(4);

        // Reset with two reads in flight: they must never come back
        apply(r5, 1'b0, '0, 1'b0, 1'b1, 1'b0, rd(64'h2A), 1'b0, '0, 1'b0);
        apply('0, 1'b0, r6, 1'b0, 1'b0, 1'b1, '0, 1'b0, rd(64'h66), 1'b0);
        rst_n = 1'b0;
        exp0_q.delete();
        exp1_q.delete();
        req0 = r5; req1 = '0;
        @(negedge clk);
        chk("rst2_ready0", 96'(rdy0), 96'(0));
        chk("rst2_ram_req", ram_req, 96'(0));
        pend_ram = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // After reset req0 wins first; then round-robin or fixed priority
        for (int i = 0; i < 8; i++) begin
            e0 = fixed || (i % 2 == 0);
            apply(r5, 1'b0, r6, 1'b0, e0, !e0, rd(64'h2A), 1'b0, rd(64'h66), 1'b0);
        end

        // Both request with lock: winner owns the port, loser waits
        apply(r5, 1'b1, r6, 1'b1, 1'b1, 1'b0, rd(64'h2A), 1'b0, rd(64'h66), 1'b0);
        apply(r5, 1'b0, r6, 1'b1, 1'b1, 1'b0, rd(64'h2A), 1'b0, rd(64'h66), 1'b0);
        apply('0, 1'b0, r6, 1'b0, 1'b0, 1'b1, '0, 1'b0, rd(64'h66), 1'b0);
        idle(5);

        chk("exp0_left", 96'(exp0_q.size()), 96'(0));
        chk("exp1_left", 96'(exp1_q.size()), 96'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
